// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, initial hash value and round functions used by the
// compression engine and its message schedule.
package sha256_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {IDLE, ROUNDS, FINAL, DONE} state_e;

  localparam word_t IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t Ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t Maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic word_t S0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t S1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t s0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t s1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_msg_schedule.sv
// 16-word sliding message window; win[0] is always W_t for the current round
// and each shift appends W_{t+16} at the top.
module sha256_msg_schedule
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [511:0] block_i,
  output word_t        w_o
);

  word_t win_q [16];
  word_t win_d [16];
  word_t wNext;

  always_comb begin
    wNext = s1(win_q[14]) + win_q[9] + s0(win_q[1]) + win_q[0];
    win_d = win_q;
    if (load_i) begin
      for (int i = 0; i < 16; i++) win_d[i] = block_i[511 - 32*i -: 32];
    end else if (shift_i) begin
      for (int i = 0; i < 15; i++) win_d[i] = win_q[i + 1];
      win_d[15] = wNext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
    end else begin
      win_q <= win_d;
    end
  end

  assign w_o = win_q[0];

endmodule

// File: rtl/sha256_compress_engine.sv
// Iterative SHA-256 compression: one round per clock, external K ROM,
// chaining value H kept across blocks until block_init restarts from IV.
module sha256_compress_engine
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         block_valid,
  output logic         block_ready,
  input  logic [511:0] block_data,
  input  logic         block_init,
  output logic [5:0]   k_addr,
  input  logic [31:0]  k_data,
  output logic         digest_valid,
  input  logic         digest_ready,
  output logic [255:0] digest
);

  state_e     state_q, state_d;
  logic [5:0] t_q, t_d;
  word_t      wv_q [8];
  word_t      wv_d [8];
  word_t      h_q [8];
  word_t      h_d [8];
  word_t      wT, t1, t2;
  logic       accept;

  assign accept = (state_q == IDLE) && block_valid;

  sha256_msg_schedule u_sched (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (accept),
    .shift_i (state_q == ROUNDS),
    .block_i (block_data),
    .w_o     (wT)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (block_valid) state_d = ROUNDS;
      ROUNDS:  if (t_q == 6'd63) state_d = FINAL;
      FINAL:   state_d = DONE;
      DONE:    if (digest_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    block_ready  = (state_q == IDLE);
    digest_valid = (state_q == DONE);
    k_addr       = (state_q == ROUNDS) ? t_q : 6'd0;
    digest       = {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4], h_q[5], h_q[6], h_q[7]};
  end

  // wv index 0..7 holds working variables a..h
  always_comb begin
    t1   = wv_q[7] + S1(wv_q[4]) + Ch(wv_q[4], wv_q[5], wv_q[6]) + k_data + wT;
    t2   = S0(wv_q[0]) + Maj(wv_q[0], wv_q[1], wv_q[2]);
    wv_d = wv_q;
    h_d  = h_q;
    t_d  = t_q;
    case (state_q)
      IDLE: begin
        if (block_valid) begin
          for (int i = 0; i < 8; i++) begin
            wv_d[i] = block_init ? IV[i] : h_q[i];
            if (block_init) h_d[i] = IV[i];
          end
          t_d = 6'd0;
        end
      end
      ROUNDS: begin
        wv_d[0] = t1 + t2;
        wv_d[1] = wv_q[0];
        wv_d[2] = wv_q[1];
        wv_d[3] = wv_q[2];
        wv_d[4] = wv_q[3] + t1;
        wv_d[5] = wv_q[4];
        wv_d[6] = wv_q[5];
        wv_d[7] = wv_q[6];
        t_d     = t_q + 6'd1;
      end
      FINAL: begin
        for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + wv_q[i];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q <= 6'd0;
      for (int i = 0; i < 8; i++) begin
        wv_q[i] <= '0;
        h_q[i]  <= IV[i];
      end
    end else begin
      t_q  <= t_d;
      wv_q <= wv_d;
      h_q  <= h_d;
    end
  end

endmodule

// File: tb/tb_sha256_compress_engine.sv
// Scoreboard bench for the SHA-256 compression engine using FIPS 180 example
// digests; the bench supplies its own K ROM.
module tb_sha256_compress_engine;

  localparam logic [255:0] IV_DIGEST    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_DIGEST   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_DIGEST = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] TWO_DIGEST   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [511:0] ABC_BLOCK   = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] EMPTY_BLOCK = {32'h80000000, {15{32'h0}}};
  localparam logic [511:0] TWO_BLOCK1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                          32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                          32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                          32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_BLOCK2  = {{15{32'h0}}, 32'h000001c0};

  logic         clk = 1'b0;
  logic         rstN;
  logic         blockValid;
  logic         blockReady;
  logic [511:0] blockData;
  logic         blockInit;
  logic [5:0]   kAddr;
  logic [31:0]  kData;
  logic         digestValid;
  logic         digestReady;
  logic [255:0] digest;

  typedef struct {
    logic [255:0] digest;
    bit           check;
    string        name;
  } sbEntry_t;

  sbEntry_t sbQueue [$];
  int errCount   = 0;
  int checkCount = 0;

  logic [31:0] kRom [64];

  initial begin
    kRom = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
  end

  assign kData = kRom[kAddr];

  always #5 clk = ~clk;

  sha256_compress_engine dut (
    .clk          (clk),
    .rst_n        (rstN),
    .block_valid  (blockValid),
    .block_ready  (blockReady),
    .block_data   (blockData),
    .block_init   (blockInit),
    .k_addr       (kAddr),
    .k_data       (kData),
    .digest_valid (digestValid),
    .digest_ready (digestReady),
    .digest       (digest)
  );

  task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    checkCount++;
    errCount++;
    $display("[TB] FAIL %s: timed out waiting", name);
  endtask

  // Monitor: every accepted digest is matched against the oldest expectation
  always @(negedge clk) begin
    if (rstN && digestValid && digestReady) begin
      if (sbQueue.size() == 0) begin
        reportTimeout("unexpected digest with empty scoreboard");
      end else begin
        sbEntry_t e;
        e = sbQueue.pop_front();
        if (e.check) checkOutput(e.name, digest, e.digest);
      end
    end
  end

  // sbMode: 0 = no expectation, 1 = push and check, 2 = push but do not check
  task automatic applyStimulus(input logic [511:0] data, input logic init, input logic [255:0] expDigest,
                               input int sbMode, input string name);
    int budget;
    sbEntry_t e;
    budget = 0;
    @(negedge clk);
    while (!blockReady && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    if (!blockReady) begin
      reportTimeout({name, " block_ready"});
      return;
    end
    if (sbMode != 0) begin
      e.digest = expDigest;
      e.check  = (sbMode == 1);
      e.name   = name;
      sbQueue.push_back(e);
    end
    blockData  = data;
    blockInit  = init;
    blockValid = 1'b1;
    @(posedge clk);
    #1 blockValid = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int budget;
    budget = 0;
    while (sbQueue.size() != 0 && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    if (sbQueue.size() != 0) begin
      reportTimeout({name, " digest"});
      sbQueue.delete();
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int kBad, vBad, unstable, rdyBad, budget;
    logic [255:0] held;

    rstN        = 1'b0;
    blockValid  = 1'b0;
    blockData   = '0;
    blockInit   = 1'b0;
    digestReady = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset block_ready", {255'd0, blockReady}, 256'd1);
    checkOutput("reset digest_valid", {255'd0, digestValid}, 256'd0);
    checkOutput("reset digest", digest, IV_DIGEST);
    checkOutput("reset k_addr", {250'd0, kAddr}, 256'd0);
    @(posedge clk);
    #1 rstN = 1'b1;

    $display("[TB] abc block with latency and k_addr trace");
    applyStimulus(ABC_BLOCK, 1'b1, ABC_DIGEST, 1, "abc digest");
    kBad = 0;
    vBad = 0;
    for (int i = 1; i <= 66; i++) begin
      @(negedge clk);
      if (kAddr !== ((i <= 64) ? 6'(i - 1) : 6'd0)) kBad++;
      if (digestValid !== (i == 66)) vBad++;
    end
    checkOutput("k_addr trace errors", 256'(kBad), 256'd0);
    checkOutput("digest_valid latency errors", 256'(vBad), 256'd0);
    waitDrain("abc");

    $display("[TB] empty-string block");
    applyStimulus(EMPTY_BLOCK, 1'b1, EMPTY_DIGEST, 1, "empty digest");
    waitDrain("empty");

    $display("[TB] two-block chained message");
    applyStimulus(TWO_BLOCK1, 1'b1, '0, 2, "two-block first");
    applyStimulus(TWO_BLOCK2, 1'b0, TWO_DIGEST, 1, "two-block digest");
    waitDrain("two-block");

    $display("[TB] digest back-pressure");
    @(posedge clk);
    #1 digestReady = 1'b0;
    applyStimulus(EMPTY_BLOCK, 1'b1, EMPTY_DIGEST, 1, "back-pressure digest");
    budget = 0;
    while (!digestValid && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (!digestValid) reportTimeout("back-pressure digest_valid");
    held       = digest;
    blockData  = ABC_BLOCK;
    blockInit  = 1'b1;
    blockValid = 1'b1;
    unstable   = 0;
    rdyBad     = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (digest !== held || digestValid !== 1'b1) unstable++;
      if (blockReady !== 1'b0) rdyBad++;
    end
    checkOutput("digest stable under back-pressure", 256'(unstable), 256'd0);
    checkOutput("block_ready low under back-pressure", 256'(rdyBad), 256'd0);
    @(posedge clk);
    #1 blockValid = 1'b0;
    digestReady = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("block_ready after release", {255'd0, blockReady}, 256'd1);
    repeat (3) @(negedge clk);
    checkOutput("blocked request not stored k_addr", {250'd0, kAddr}, 256'd0);
    checkOutput("blocked request not stored ready", {255'd0, blockReady}, 256'd1);

    $display("[TB] reset in the middle of rounds");
    applyStimulus(ABC_BLOCK, 1'b1, '0, 0, "aborted");
    budget = 0;
    while (kAddr !== 6'd30 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (kAddr !== 6'd30) reportTimeout("round 30");
    rstN = 1'b0;
    #1;
    checkOutput("mid-reset block_ready", {255'd0, blockReady}, 256'd1);
    checkOutput("mid-reset digest_valid", {255'd0, digestValid}, 256'd0);
    checkOutput("mid-reset digest", digest, IV_DIGEST);
    @(posedge clk);
    #1 rstN = 1'b1;
    applyStimulus(ABC_BLOCK, 1'b0, ABC_DIGEST, 1, "abc after reset chained from IV");
    waitDrain("abc after reset");

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
